key_event_scheduler: RTL

//  Buffers ASCII key events from the PS/2 keyboard front end (ascii_out/ascii_ready pulse pair)
//  and schedules them to a single consumer (game/render control) over a valid/ready handshake.

---
 rtl/key_pkg.sv | 19 +
 rtl/key_fifo.sv | 65 ++++++
 rtl/key_event_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared widths, ASCII code points and output-stage state encoding for the key event scheduler.
package key_pkg;

   localparam int KEY_W = 8;

   localparam logic [KEY_W-1:0] ASCII_ESC   = 8'd27;
   localparam logic [KEY_W-1:0] ASCII_ENTER = 8'd13;
   localparam logic [KEY_W-1:0] ASCII_NONE  = 8'd0;

   typedef enum logic {
      O_EMPTY = 1'b0,
      O_FULL  = 1'b1
   } out_state_e;

   function automatic logic is_mapped(input logic [KEY_W-1:0] code);
      return code != ASCII_NONE;
   endfunction

endpackage

// File: rtl/key_fifo.sv
// Circular key buffer with push/pop/flush; a push in the flush cycle lands at index 0.
module key_fifo
   import key_pkg::*;
#(
   parameter int  DEPTH = 8,
   localparam int CW    = $clog2(DEPTH)
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [KEY_W-1:0] data_i,
   output logic [KEY_W-1:0] data_o,
   output logic [CW:0]      count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [KEY_W-1:0] mem_q [DEPTH];
   logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW:0]      count_q, count_d;
   logic [CW-1:0]    wr_idx;

   assign wr_idx = flush_i ? '0 : wr_ptr_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = push_i ? CW'(1) : '0;
         count_d  = push_i ? (CW+1)'(1) : '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + CW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + CW'(1);
         count_d = count_q + (CW+1)'(push_i) - (CW+1)'(pop_i);
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count alone decides what is readable.
   always_ff @(posedge Clock) begin
      if (push_i) mem_q[wr_idx] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = count_q == (CW+1)'(DEPTH);
   assign empty_o = count_q == '0;

endmodule

// File: rtl/key_event_scheduler.sv
// Queues keyboard ASCII events for one valid/ready consumer; ESC flushes queued keys.
// Build option: KEYQ_DROP_CNT_EN adds a saturating drop_count output.
//
//   state   | meaning
//   O_EMPTY | output register holds nothing, out_valid=0
//   O_FULL  | output register committed to consumer, out_valid=1
module key_event_scheduler
   import key_pkg::*;
#(
   parameter int  DEPTH = 8,
   localparam int CW    = $clog2(DEPTH)
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic [KEY_W-1:0] in_ascii,
   input  logic             in_valid,
   output logic [KEY_W-1:0] out_ascii,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW:0]      level,
   output logic             overflow,
   input  logic             clr_overflow
`ifdef KEYQ_DROP_CNT_EN
   ,
   output logic [7:0]       drop_count
`endif
);

   out_state_e       state_q, state_d;
   logic [KEY_W-1:0] out_ascii_q, out_ascii_d;
   logic             overflow_q, overflow_d;

   logic             accept, is_esc, out_free, drop;
   logic             fifo_push, fifo_pop, fifo_flush;
   logic [KEY_W-1:0] fifo_dout;
   logic [CW:0]      fifo_count;
   logic             fifo_full, fifo_empty;

   assign accept   = in_valid && is_mapped(in_ascii);
   assign is_esc   = accept && (in_ascii == ASCII_ESC);
   assign out_free = (state_q == O_EMPTY) || out_ready;

   key_fifo #(.DEPTH(DEPTH)) u_fifo (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .flush_i (fifo_flush),
      .data_i  (in_ascii),
      .data_o  (fifo_dout),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // ESC discards the FIFO before it is placed, so it sees an empty FIFO.
   always_comb begin
      state_d     = state_q;
      out_ascii_d = out_ascii_q;
      fifo_push   = 1'b0;
      fifo_pop    = 1'b0;
      fifo_flush  = is_esc;
      drop        = 1'b0;
      if (out_free) begin
         if (!is_esc && !fifo_empty) begin
            state_d     = O_FULL;
            out_ascii_d = fifo_dout;
            fifo_pop    = 1'b1;
            fifo_push   = accept;
         end else if (accept) begin
            state_d     = O_FULL;
            out_ascii_d = in_ascii;
         end else begin
            state_d = O_EMPTY;
         end
      end else if (accept) begin
         if (!is_esc && fifo_full) drop      = 1'b1;
         else                      fifo_push = 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q     <= O_EMPTY;
         out_ascii_q <= ASCII_NONE;
      end else begin
         state_q     <= state_d;
         out_ascii_q <= out_ascii_d;
      end
   end

   // A drop in the clear cycle keeps the flag set.
   assign overflow_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);

   always_ff @(posedge Clock) begin
      if (!Resetn) overflow_q <= 1'b0;
      else         overflow_q <= overflow_d;
   end

`ifdef KEYQ_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         if (clr_overflow)              drop_cnt_d = 8'd1;
         else if (drop_cnt_q != 8'hFF)  drop_cnt_d = drop_cnt_q + 8'd1;
      end else if (clr_overflow) begin
         drop_cnt_d = 8'd0;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) drop_cnt_q <= 8'd0;
      else         drop_cnt_q <= drop_cnt_d;
   end

   assign drop_count = drop_cnt_q;
`endif

   assign out_ascii = out_ascii_q;
   assign out_valid = state_q == O_FULL;
   assign level     = fifo_count + (CW+1)'(state_q == O_FULL);
   assign overflow  = overflow_q;

endmodule
